inv_subbytes_seq: RTL and testbench
===================================

INV_SUBBYTES_SEQ -- requirements
Module: inv_subbytes_seq

Interface
REQ-001 Parameter: LANES, default 4, number of shared inverse S-box instances; legal values 1, 2, 4, 8, 16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 clr  input  1  synchronous abort; returns block to IDLE.
REQ-005 in_valid  input  1  data_in carries a 128-bit state to transform.
REQ-006 in_ready  output  1  block can accept a state this cycle.
REQ-007 data_in  input  128  AES state; byte i = data_in[127-8i -: 8], column-major (i = 4*col + row).
REQ-008 out_valid  output  1  data_out holds a completed result.
REQ-009 out_ready  input  1  consumer accepts data_out.
REQ-010 data_out  output  128  transformed state, same byte ordering as data_in.
REQ-011 busy  output  1  high in RUN and DONE.

Function
REQ-012 Block instantiates exactly LANES sbox_inverse instances and time-multiplexes them over the 16 state bytes.
REQ-013 FSM states: IDLE, RUN, DONE; in_ready = (state == IDLE).
REQ-014 IDLE -> RUN on in_valid & in_ready; data_in captured into an internal 128-bit register; step counter cleared to 0.
REQ-015 In RUN, in step c, lane k substitutes byte c*LANES+k; step counter increments by 1 per cycle.
REQ-016 RUN lasts exactly 16/LANES cycles; RUN -> DONE after the final step (counter == 16/LANES-1).
REQ-017 Latency: out_valid asserts 16/LANES+1 cycles after the accepting edge (5 cycles for LANES=4).
REQ-018 In DONE, out_valid = 1 and data_out stable; DONE -> IDLE on out_ready.
REQ-019 out_valid held with data_out unchanged for any number of cycles while out_ready = 0.
REQ-020 in_valid in RUN or DONE is ignored; no capture, no corruption.
REQ-021 clr has priority over all transitions: any state -> IDLE next cycle; out_valid = 0; partial result discarded.
REQ-022 Step counter width = ceil(log2(16/LANES)), minimum 1 bit; no wrap beyond the final step.
REQ-023 No back-to-back overlap: the next in_valid accepted no earlier than the cycle after DONE exits.

Reset
REQ-024 On rst_n = 0, immediately: state = IDLE, step counter = 0, internal state register = 0.
REQ-025 Reset outputs: in_ready = 1 (once rst_n released), out_valid = 0, busy = 0, data_out = 128'h0.
REQ-026 Reset asserted mid-RUN or mid-DONE aborts the operation; no result is emitted after release.

Configuration
REQ-027 Macro INV_SHIFTROWS_FUSE_EN.
REQ-028 Defined: the result of input byte (row r, col c) is written to output position (row r, col (c+r) mod 4), i.e. InvShiftRows is fused; latency unchanged.
REQ-029 Undefined: the result of input byte i is written to output byte i (pure InvSubBytes).

Verification
REQ-030 data_in = 16 bytes 0x63, LANES=4 -> data_out = 128'h0 with out_valid exactly 5 cycles after acceptance.
REQ-031 data_in = 00 01 02 ... 0F, fuse undefined -> data_out = 52 09 6A D5 30 36 A5 38 BF 40 A3 9E 81 F3 D7 FB.
REQ-032 Same input, INV_SHIFTROWS_FUSE_EN defined -> data_out = 52 F3 A3 38 30 09 D7 9E BF 36 6A FB 81 40 A5 D5.
REQ-033 out_ready held 0 for 10 cycles in DONE, in_valid pulsed meanwhile -> data_out stable, in_ready = 0, no second capture.
REQ-034 rst_n pulsed low during step 2 of RUN -> out_valid = 0, data_out = 0 immediately; next accepted vector completes correctly.
REQ-035 LANES = 1 and LANES = 16 with vector 0x00..0x0F -> identical data_out to REQ-031, latency 17 and 2 cycles respectively.

Source files
------------

// File: rtl/inv_subbytes_seq.sv
// Iterative AES InvSubBytes over a 128-bit state using LANES shared inverse S-boxes.
// Define INV_SHIFTROWS_FUSE_EN to fuse InvShiftRows into the result placement.
module sbox_inverse (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    assign o_byte = gf_inv(inv_affine(i_byte));
endmodule

module inv_subbytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);
    localparam int STEPS = 16 / LANES;
    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_step;
    logic [127:0]   r_data;
    logic [127:0]   r_res;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           r_busy;
    logic [7:0]     w_lane_in  [LANES];
    logic [7:0]     w_lane_out [LANES];

    function automatic int src_idx(input logic [CW-1:0] step, input int k);
        return int'(step) * LANES + k;
    endfunction

    // Output byte position for a given input byte position.
    function automatic int dst_idx(input int i);
`ifdef INV_SHIFTROWS_FUSE_EN
        return 4 * (((i / 4) + (i % 4)) % 4) + (i % 4);
`else
        return i;
`endif
    endfunction

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_lane_in[k] = r_data[8*(15-src_idx(r_step, k)) +: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox_inverse u_sbox (
            .i_byte (w_lane_in[g]),
            .o_byte (w_lane_out[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_step      <= '0;
            r_data      <= '0;
            r_res       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (clr) begin
            r_state     <= IDLE;
            r_step      <= '0;
            r_data      <= '0;
            r_res       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state    <= RUN;
                        r_data     <= data_in;
                        r_step     <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    for (int k = 0; k < LANES; k++) begin
                        r_res[8*(15-dst_idx(src_idx(r_step, k))) +: 8] <= w_lane_out[k];
                    end
                    if (r_step == LAST) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign data_out  = r_res;
endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Bench for inv_subbytes_seq: LANES = 4, 1 and 16 instances against a table-based model.
// Latency is counted from the cycle in_valid is presented to the first cycle out_valid is high.
module tb_inv_subbytes_seq;
    logic         clk;
    logic         rst_n;
    logic         clr;
    logic         in_valid_a  [3];
    logic         in_ready_a  [3];
    logic [127:0] din_a       [3];
    logic         out_valid_a [3];
    logic         out_ready_a [3];
    logic [127:0] dout_a      [3];
    logic         busy_a      [3];

    int npass = 0;
    int ntot  = 0;
    logic [7:0] isb [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_subbytes_seq #(
            .LANES ((g == 0) ? 4 : ((g == 1) ? 1 : 16))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .data_in   (din_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .data_out  (dout_a[g]),
            .busy      (busy_a[g])
        );
    end

    function automatic int lanes_of(input int u);
        return (u == 0) ? 4 : ((u == 1) ? 1 : 16);
    endfunction

    // Carry-less product then long division by the AES polynomial 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] w;
        w = {b, b} << n;
        return w[15:8];
    endfunction

    // Forward S-box: brute-force inverse, then the forward affine map.
    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] o;
        int r, c, dst;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            r = i % 4;
            c = i / 4;
`ifdef INV_SHIFTROWS_FUSE_EN
            dst = 4 * ((c + r) % 4) + r;
`else
            dst = i;
`endif
            o[8*(15-dst) +: 8] = isb[d[8*(15-i) +: 8]];
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic start(input int u, input logic [127:0] d);
        @(negedge clk);
        chk($sformatf("u%0d in_ready before accept", u), 128'(in_ready_a[u]), 128'd1);
        in_valid_a[u] = 1'b1;
        din_a[u]      = d;
        @(negedge clk);
        in_valid_a[u] = 1'b0;
        din_a[u]      = '0;
    endtask

    task automatic wait_done(input int u, input logic [127:0] exp, input string tag);
        int lat;
        lat = 1;
        while (!out_valid_a[u] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 128'(lat), 128'(16 / lanes_of(u) + 1));
        chk({tag, " data"}, dout_a[u], exp);
        chk({tag, " busy"}, 128'(busy_a[u]), 128'd1);
        chk({tag, " in_ready"}, 128'(in_ready_a[u]), 128'd0);
    endtask

    task automatic finish(input int u, input string tag);
        out_ready_a[u] = 1'b1;
        @(negedge clk);
        out_ready_a[u] = 1'b0;
        chk({tag, " out_valid drop"}, 128'(out_valid_a[u]), 128'd0);
        chk({tag, " idle in_ready"}, 128'(in_ready_a[u]), 128'd1);
    endtask

    task automatic run(input int u, input logic [127:0] d, input logic [127:0] exp, input string tag);
        start(u, d);
        wait_done(u, exp, tag);
        finish(u, tag);
    endtask

    initial begin
        logic [127:0] v, exp, held;
        logic [127:0] ramp;
        logic [127:0] ramp_exp;
        rst_n = 1'b0;
        clr   = 1'b0;
        for (int u = 0; u < 3; u++) begin
            in_valid_a[u]  = 1'b0;
            out_ready_a[u] = 1'b0;
            din_a[u]       = '0;
        end
        for (int x = 0; x < 256; x++) isb[fwd_sbox(8'(x))] = 8'(x);

        #2;
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d reset out_valid", u), 128'(out_valid_a[u]), 128'd0);
            chk($sformatf("u%0d reset busy", u), 128'(busy_a[u]), 128'd0);
            chk($sformatf("u%0d reset data_out", u), dout_a[u], 128'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d in_ready after reset", u), 128'(in_ready_a[u]), 128'd1);
        end

        run(0, {16{8'h63}}, 128'h0, "all63");

        ramp = 128'h000102030405060708090a0b0c0d0e0f;
`ifdef INV_SHIFTROWS_FUSE_EN
        ramp_exp = 128'h52f3a3383009d79ebf366afb8140a5d5;
`else
        ramp_exp = 128'h52096ad53036a538bf40a39e81f3d7fb;
`endif
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d model ramp", u), model(ramp), ramp_exp);
            run(u, ramp, ramp_exp, $sformatf("u%0d ramp", u));
        end

        for (int n = 0; n < 12; n++) begin
            for (int u = 0; u < 3; u++) begin
                v = {$urandom, $urandom, $urandom, $urandom};
                run(u, v, model(v), $sformatf("u%0d rand%0d", u, n));
            end
        end

        // Stall in DONE with in_valid pulses; the held result must not move.
        v = {$urandom, $urandom, $urandom, $urandom};
        exp = model(v);
        start(0, v);
        wait_done(0, exp, "stall");
        held = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 10; i++) begin
            in_valid_a[0] = (i == 3 || i == 4);
            din_a[0]      = held;
            @(negedge clk);
            chk($sformatf("stall%0d data", i), dout_a[0], exp);
            chk($sformatf("stall%0d out_valid", i), 128'(out_valid_a[0]), 128'd1);
            chk($sformatf("stall%0d in_ready", i), 128'(in_ready_a[0]), 128'd0);
        end
        in_valid_a[0] = 1'b0;
        din_a[0]      = '0;
        finish(0, "stall");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("no second capture %0d", i), 128'(busy_a[0]), 128'd0);
        end

        // Asynchronous reset during step 2 of RUN.
        v = {$urandom, $urandom, $urandom, $urandom};
        start(0, v);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst mid-run out_valid", 128'(out_valid_a[0]), 128'd0);
        chk("rst mid-run data_out", dout_a[0], 128'd0);
        chk("rst mid-run busy", 128'(busy_a[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("rst no result %0d", i), 128'(out_valid_a[0]), 128'd0);
        end
        v = {$urandom, $urandom, $urandom, $urandom};
        run(0, v, model(v), "after rst");

        // Synchronous clear mid-RUN and in DONE.
        v = {$urandom, $urandom, $urandom, $urandom};
        start(0, v);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr run busy", 128'(busy_a[0]), 128'd0);
        chk("clr run in_ready", 128'(in_ready_a[0]), 128'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("clr run no result %0d", i), 128'(out_valid_a[0]), 128'd0);
        end
        v = {$urandom, $urandom, $urandom, $urandom};
        start(0, v);
        wait_done(0, model(v), "pre clr done");
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr done out_valid", 128'(out_valid_a[0]), 128'd0);
        chk("clr done in_ready", 128'(in_ready_a[0]), 128'd1);
        v = {$urandom, $urandom, $urandom, $urandom};
        run(0, v, model(v), "after clr");

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
